// File: rtl/arith_pkg.sv
// Shared definitions for arith_seq_unit: operation encoding and FSM states.
package arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/arith_seq_unit_ripple_adder.sv
// Combinational WIDTH-bit ripple-carry adder: sum = {carry_out, a + b + cin}.
module ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   sum
);

  // Bit-serial carry chain; the carry ripples from bit 0 upward.
  always_comb begin
    logic carry;
    // NOTE: blocking assignments here are intentional; each bit needs the carry
    // just produced by the bit below it within the same evaluation.
    carry = cin;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
    end
    sum[WIDTH] = carry;
  end

endmodule

// File: rtl/arith_seq_unit.sv
// Multi-cycle arithmetic unit: single-pass add-with-carry or WIDTH-iteration
// shift-add unsigned multiply behind a start/ready/done handshake.
// Optional macro ARITH_ACC_EN turns MUL into a multiply-accumulate with a
// sticky overflow flag (ports acc_clr / acc_ovf).
module arith_seq_unit
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH:0]     sum,
  output logic [2*WIDTH-1:0] product
`ifdef ARITH_ACC_EN
  ,
  input  logic               acc_clr,
  output logic               acc_ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;        // addend A / multiplicand
  logic [WIDTH-1:0]     b_q, b_d;        // addend B
  logic                 cin_q, cin_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   pp_q, pp_d;      // partial product; multiplier shifts out of the low half
  logic [WIDTH:0]       sum_q, sum_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
`ifdef ARITH_ACC_EN
  logic                 acc_clr_q, acc_clr_d;
  logic                 acc_ovf_q, acc_ovf_d;
  logic [2*WIDTH:0]     acc_sum;
`endif

  logic [WIDTH-1:0]     add_a, add_b;
  logic                 add_cin;
  logic [WIDTH:0]       add_sum;
  logic [2*WIDTH-1:0]   pp_step;

  // Operand mux: the one adder serves ADD directly and the MUL partial-sum step.
  always_comb begin
    add_a   = a_q;
    add_b   = b_q;
    add_cin = cin_q;
    if (state_q == MUL) begin
      add_a   = pp_q[2*WIDTH-1:WIDTH];
      add_b   = a_q;
      add_cin = 1'b0;
    end
  end

  ripple_adder #(.WIDTH(WIDTH)) u_adder (
    .a   (add_a),
    .b   (add_b),
    .cin (add_cin),
    .sum (add_sum)
  );

  // One shift-add iteration: conditionally add multiplicand into the upper half, then shift right.
  always_comb begin
    if (pp_q[0]) pp_step = {add_sum, pp_q[WIDTH-1:1]};
    else         pp_step = {1'b0, pp_q[2*WIDTH-1:1]};
  end

`ifdef ARITH_ACC_EN
  // Accumulate the finished product onto the held result (or onto zero when clearing).
  always_comb begin
    acc_sum = (acc_clr_q ? {(2*WIDTH+1){1'b0}} : {1'b0, product_q}) + {1'b0, pp_step};
  end
`endif

  // Next-state and datapath update logic.
  always_comb begin
    // NOTE: every *_d gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    cnt_d     = cnt_q;
    pp_d      = pp_q;
    sum_d     = sum_q;
    product_d = product_q;
`ifdef ARITH_ACC_EN
    acc_clr_d = acc_clr_q;
    acc_ovf_d = acc_ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          cin_d = cin;
          if (op == OP_MUL) begin
            state_d = MUL;
            cnt_d   = CNT_W'(WIDTH);
            pp_d    = {{WIDTH{1'b0}}, b};
`ifdef ARITH_ACC_EN
            acc_clr_d = acc_clr;
`endif
          end else begin
            state_d = ADD;
          end
        end
      end
      ADD: begin
        sum_d   = add_sum;
        state_d = DONE;
      end
      MUL: begin
        pp_d  = pp_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
`ifdef ARITH_ACC_EN
          product_d = acc_sum[2*WIDTH-1:0];
          acc_ovf_d = (acc_ovf_q & ~acc_clr_q) | acc_sum[2*WIDTH];
`else
          product_d = pp_step;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is plain control/datapath (no memory arrays), so all
    // of them take a defined reset value; an abort mid-operation leaves nothing stale.
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      cnt_q     <= '0;
      pp_q      <= '0;
      sum_q     <= '0;
      product_q <= '0;
`ifdef ARITH_ACC_EN
      acc_clr_q <= 1'b0;
      acc_ovf_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      cnt_q     <= cnt_d;
      pp_q      <= pp_d;
      sum_q     <= sum_d;
      product_q <= product_d;
`ifdef ARITH_ACC_EN
      acc_clr_q <= acc_clr_d;
      acc_ovf_q <= acc_ovf_d;
`endif
    end
  end

  assign ready   = (state_q == IDLE);
  assign busy    = (state_q == ADD) || (state_q == MUL);
  assign done    = (state_q == DONE);
  assign sum     = sum_q;
  assign product = product_q;
`ifdef ARITH_ACC_EN
  assign acc_ovf = acc_ovf_q;
`endif

endmodule

// File: tb/tb_arith_seq_unit.sv
// Scoreboard testbench for arith_seq_unit (WIDTH=4). Driver pushes expected
// results from a plain-arithmetic model; a negedge monitor pops on done.
module tb_arith_seq_unit;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           op = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           cin = 1'b0;
  logic           ready, busy, done;
  logic [W:0]     sum;
  logic [2*W-1:0] product;
`ifdef ARITH_ACC_EN
  logic           acc_clr = 1'b0;
  logic           acc_ovf;
`endif

  arith_seq_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .product (product)
`ifdef ARITH_ACC_EN
    ,
    .acc_clr (acc_clr),
    .acc_ovf (acc_ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic           op;
    logic [W:0]     sum;
    logic [2*W-1:0] prod;
    logic           ovf;
    int             issue;
  } exp_t;

  exp_t sb[$];

  // Reference model state: the held results as the spec describes them.
  logic [W:0]     m_sum = '0;
  logic [2*W-1:0] m_prod = '0;
  logic           m_ovf = 1'b0;

  task automatic model_reset();
    m_sum  = '0;
    m_prod = '0;
    m_ovf  = 1'b0;
    sb.delete();
  endtask

  task automatic push_expect(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic c, input logic clr);
    exp_t e;
    logic [2*W:0] full;
    if (o == 1'b0) begin
      m_sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    end else begin
`ifdef ARITH_ACC_EN
      full   = (clr ? {(2*W+1){1'b0}} : {1'b0, m_prod}) + (2*W+1)'(x * y);
      m_ovf  = (clr ? 1'b0 : m_ovf) | full[2*W];
      m_prod = full[2*W-1:0];
`else
      full   = (2*W+1)'(x) * (2*W+1)'(y);
      m_prod = full[2*W-1:0];
`endif
    end
    e.op = o; e.sum = m_sum; e.prod = m_prod; e.ovf = m_ovf; e.issue = cyc;
    sb.push_back(e);
  endtask

  // Monitor: protocol sanity every cycle, scoreboard compare on each done.
  always @(negedge clk) begin
    if (rst_n) begin
      check("one_of_ready_busy_done", 64'(ready) + 64'(busy) + 64'(done), 64'd1);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check(e.op ? "mul_sum_held" : "add_sum", 64'(sum), 64'(e.sum));
          check(e.op ? "mul_product" : "add_product_held", 64'(product), 64'(e.prod));
          check("latency", 64'(cyc - e.issue), e.op ? 64'(W + 1) : 64'd2);
`ifdef ARITH_ACC_EN
          check("acc_ovf", 64'(acc_ovf), 64'(e.ovf));
`endif
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 64'(ready), 64'd1);
  endtask

  // Issue one op, then scramble operands so post-accept changes are exercised.
  task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input logic clr);
    wait_ready();
    start = 1'b1; op = o; a = x; b = y; cin = c;
`ifdef ARITH_ACC_EN
    acc_clr = clr;
`endif
    push_expect(o, x, y, c, clr);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); op = 1'($urandom);
  endtask

  // Random traffic; with held=1 start stays high so accepts happen only on ready.
  task automatic random_run(input int n, input bit held);
    for (int i = 0; i < n; i++) begin
      logic clr;
      start = held ? 1'b1 : 1'($urandom);
      op = 1'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      clr = ($urandom_range(0, 3) == 0);
`ifdef ARITH_ACC_EN
      acc_clr = clr;
`endif
      if (start && ready) push_expect(op, a, b, cin, clr);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"},   64'(ready),   64'd1);
    check({tag, "_busy"},    64'(busy),    64'd0);
    check({tag, "_done"},    64'(done),    64'd0);
    check({tag, "_sum"},     64'(sum),     64'd0);
    check({tag, "_product"}, 64'(product), 64'd0);
`ifdef ARITH_ACC_EN
    check({tag, "_acc_ovf"}, 64'(acc_ovf), 64'd0);
`endif
  endtask

  initial begin
    int n;
    #1;
    check_reset_values("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed ADD and MUL vectors, including the all-ones extremes.
    do_op(1'b0, 4'hE, 4'hA, 1'b0, 1'b0);
    do_op(1'b0, 4'hB, 4'h6, 1'b1, 1'b0);
    do_op(1'b1, 4'hE, 4'hA, 1'b0, 1'b1);
    do_op(1'b1, 4'h8, 4'hA, 1'b0, 1'b1);
    do_op(1'b1, 4'h3, 4'h0, 1'b0, 1'b1);
    do_op(1'b0, 4'hF, 4'hF, 1'b1, 1'b0);
    do_op(1'b1, 4'hF, 4'hF, 1'b0, 1'b1);
    do_op(1'b0, 4'h1, 4'h2, 1'b0, 1'b0);

    // Start pulse with new operands while MUL is busy must be ignored.
    do_op(1'b1, 4'hE, 4'hA, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 4'h5; b = 4'h5; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;

`ifdef ARITH_ACC_EN
    do_op(1'b1, 4'hF, 4'hF, 1'b0, 1'b1);
    do_op(1'b1, 4'hF, 4'hF, 1'b0, 1'b0);
    do_op(1'b1, 4'h1, 4'h1, 1'b0, 1'b1);
`endif

    random_run(40, 1'b1);
    random_run(80, 1'b0);

    // Reset in the middle of a MUL: immediate reset values, no done afterwards.
    do_op(1'b1, 4'h7, 4'h9, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    do_op(1'b0, 4'hE, 4'hA, 1'b0, 1'b0);
    do_op(1'b1, 4'hE, 4'hA, 1'b0, 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_outstanding", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
